lc3_mem_responder: RTL

//  Memory-side partner of the LC3 core: serves the Fetch port (pc/instrmem_rd -> Instr_dout/complete_instr)
//  and the MemAccess port (Data_addr/Data_rd/Data_din -> Data_dout/complete_data) from one shared word array.

---
 rtl/lc3_mem_responder_if.sv | 30 +++
 rtl/lc3_mem_responder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/lc3_mem_responder_if.sv
// Core-facing bus of the LC3 memory responder: fetch port, data port,
// backdoor preload port and the sticky address-error flag.
interface lc3_mem_responder_if;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        data_en;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;
  logic        addr_err;

  modport master (
    output pc, instrmem_rd, data_en, Data_rd, Data_addr, Data_din,
           ld_en, ld_addr, ld_data,
    input  Instr_dout, complete_instr, Data_dout, complete_data, addr_err
  );

  modport slave (
    input  pc, instrmem_rd, data_en, Data_rd, Data_addr, Data_din,
           ld_en, ld_addr, ld_data,
    output Instr_dout, complete_instr, Data_dout, complete_data, addr_err
  );
endinterface

// File: rtl/lc3_mem_responder.sv
// Shared word array serving the LC3 fetch and data ports, with per-port
// programmable wait states and a backdoor preload path.
//
// state  | meaning
// S_IDLE | no access pending; zero-wait requests complete here
// S_WAIT | counting wait cycles for the address captured in last_addr
module lc3_mem_responder #(
  parameter logic [15:0] BASE_ADDR  = 16'h3000,
  parameter int          DEPTH      = 4096,
  parameter int          INSTR_WAIT = 0,
  parameter int          DATA_WAIT  = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  lc3_mem_responder_if.slave   bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);
  localparam logic [7:0]  IW      = 8'(INSTR_WAIT);
  localparam logic [7:0]  DW      = 8'(DATA_WAIT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [15:0] mem [DEPTH];

  state_t      i_state, i_state_nx, d_state, d_state_nx;
  logic [7:0]  i_cnt, i_cnt_nx, d_cnt, d_cnt_nx;
  logic [15:0] i_last, i_last_nx, d_last, d_last_nx;
  logic        i_done, d_done;
  logic        addr_err_q;

  // 16-bit wrap subtraction: addresses below BASE_ADDR land far out of range.
  logic [15:0] i_idx, d_idx, ld_idx;
  logic        i_ok, d_ok, ld_ok, d_wr;
  logic [15:0] i_word, d_word;

  assign i_idx  = bus.pc - BASE_ADDR;
  assign d_idx  = bus.Data_addr - BASE_ADDR;
  assign ld_idx = bus.ld_addr - BASE_ADDR;
  assign i_ok   = {1'b0, i_idx} < DEPTH_W;
  assign d_ok   = {1'b0, d_idx} < DEPTH_W;
  assign ld_ok  = {1'b0, ld_idx} < DEPTH_W;

  assign i_word = i_ok ? mem[i_idx[AW-1:0]] : 16'h0000;
  assign d_word = d_ok ? mem[d_idx[AW-1:0]] : 16'h0000;

  always_comb begin
    i_state_nx = i_state;
    i_cnt_nx   = i_cnt;
    i_last_nx  = i_last;
    i_done     = 1'b0;
    if (!reset) begin
      case (i_state)
        S_IDLE: if (bus.instrmem_rd) begin
          if (IW == 8'd0) i_done = 1'b1;
          else begin
            i_state_nx = S_WAIT;
            i_cnt_nx   = 8'd1;
            i_last_nx  = bus.pc;
          end
        end
        S_WAIT: if (!bus.instrmem_rd) begin
          i_state_nx = S_IDLE;
          i_cnt_nx   = 8'd0;
        end else if (bus.pc != i_last) begin
          i_cnt_nx  = 8'd1;
          i_last_nx = bus.pc;
        end else if (i_cnt == IW) begin
          i_done     = 1'b1;
          i_state_nx = S_IDLE;
          i_cnt_nx   = 8'd0;
        end else i_cnt_nx = i_cnt + 8'd1;
        default: i_state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    d_state_nx = d_state;
    d_cnt_nx   = d_cnt;
    d_last_nx  = d_last;
    d_done     = 1'b0;
    if (!reset) begin
      case (d_state)
        S_IDLE: if (bus.data_en) begin
          if (DW == 8'd0) d_done = 1'b1;
          else begin
            d_state_nx = S_WAIT;
            d_cnt_nx   = 8'd1;
            d_last_nx  = bus.Data_addr;
          end
        end
        S_WAIT: if (!bus.data_en) begin
          d_state_nx = S_IDLE;
          d_cnt_nx   = 8'd0;
        end else if (bus.Data_addr != d_last) begin
          d_cnt_nx  = 8'd1;
          d_last_nx = bus.Data_addr;
        end else if (d_cnt == DW) begin
          d_done     = 1'b1;
          d_state_nx = S_IDLE;
          d_cnt_nx   = 8'd0;
        end else d_cnt_nx = d_cnt + 8'd1;
        default: d_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i_state    <= S_IDLE;
      i_cnt      <= 8'd0;
      i_last     <= 16'h0000;
      d_state    <= S_IDLE;
      d_cnt      <= 8'd0;
      d_last     <= 16'h0000;
      addr_err_q <= 1'b0;
    end else begin
      i_state    <= i_state_nx;
      i_cnt      <= i_cnt_nx;
      i_last     <= i_last_nx;
      d_state    <= d_state_nx;
      d_cnt      <= d_cnt_nx;
      d_last     <= d_last_nx;
      addr_err_q <= addr_err_q | (i_done & ~i_ok) | (d_done & ~d_ok);
    end
  end

  assign d_wr = d_done & bus.data_en & ~bus.Data_rd & d_ok;

  // Backdoor write is issued last so it wins a same-address collision.
  always_ff @(posedge clock) begin
    if (d_wr) mem[d_idx[AW-1:0]] <= bus.Data_din;
    if (bus.ld_en && ld_ok) mem[ld_idx[AW-1:0]] <= bus.ld_data;
  end

  assign bus.complete_instr = i_done;
  assign bus.complete_data  = d_done;
  assign bus.Instr_dout     = i_done ? i_word : 16'h0000;
  assign bus.Data_dout      = (d_done && bus.Data_rd) ? d_word : 16'h0000;
  assign bus.addr_err       = addr_err_q;
endmodule
